// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing pipeline: filter opcodes,
// default line width, term width and the 8-bit clamp used at the output.
package img_proc_pkg;

  typedef enum logic [3:0] {
    OP_PASS  = 4'h0,
    OP_GAUSS = 4'h1,
    OP_SHARP = 4'h2,
    OP_SOBEL = 4'h3,
    OP_LAPL  = 4'h4,
    OP_INV   = 4'h5
  } opcode_e;

  localparam int LINE_WIDTH_DEF = 512;
  localparam int TERM_W         = 13;

  function automatic logic [7:0] clamp_u8(input logic signed [TERM_W-1:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 13'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/conv3x3_kernel.sv
// S1/S2 datapath of the 3x3 filter: raw per-opcode terms, then the combine
// step (abs/add/shift) into a signed result that the top level clamps.
module conv3x3_kernel
  import img_proc_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [71:0]              i_window,
  input  logic                     i_valid,
  input  opcode_e                  i_opcode,
  output logic signed [TERM_W-1:0] o_result,
  output logic                     o_valid
);

  typedef logic signed [TERM_W-1:0] term_t;

  logic [7:0] p [3][3];
  term_t      sum_c, gx_c, gy_c;
  term_t      s1_sum, s1_gx, s1_gy;
  logic [7:0] s1_centre;
  opcode_e    s1_op;
  logic       s1_valid;
  logic [10:0] gx_abs, gy_abs;
  logic [11:0] sobel_sum;
  term_t      combine_c;

  function automatic term_t ext(input logic [7:0] v);
    return signed'({{(TERM_W-8){1'b0}}, v});
  endfunction

  // Rows are packed top-first from bit 0; within a row the left pixel is the MSB byte.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = i_window[24*r + 8*(2-c) +: 8];
  end

  always_comb begin
    gx_c = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
         - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
    gy_c = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
         - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
    sum_c = '0;
    case (i_opcode)
      OP_GAUSS: sum_c = ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2])
                      + (ext(p[1][0]) <<< 1) + (ext(p[1][1]) <<< 2) + (ext(p[1][2]) <<< 1)
                      + ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]);
      OP_SHARP: sum_c = (ext(p[1][1]) <<< 2) + ext(p[1][1])
                      - ext(p[0][1]) - ext(p[1][0]) - ext(p[1][2]) - ext(p[2][1]);
      OP_LAPL:  sum_c = ext(p[0][1]) + ext(p[1][0]) + ext(p[1][2]) + ext(p[2][1])
                      - (ext(p[1][1]) <<< 2);
      default:  sum_c = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_gx     <= '0;
      s1_gy     <= '0;
      s1_centre <= '0;
      s1_op     <= OP_PASS;
    end else begin
      s1_valid  <= i_valid;
      s1_sum    <= sum_c;
      s1_gx     <= gx_c;
      s1_gy     <= gy_c;
      s1_centre <= p[1][1];
      s1_op     <= i_opcode;
    end
  end

  // Gradient magnitudes never exceed 1020, so 11 bits hold them and 12 bits their sum.
  always_comb begin
    gx_abs    = s1_gx[TERM_W-1] ? 11'(-s1_gx) : 11'(s1_gx);
    gy_abs    = s1_gy[TERM_W-1] ? 11'(-s1_gy) : 11'(s1_gy);
    sobel_sum = {1'b0, gx_abs} + {1'b0, gy_abs};
    combine_c = ext(s1_centre);
    case (s1_op)
      OP_GAUSS:         combine_c = s1_sum >>> 4;
      OP_SHARP, OP_LAPL: combine_c = s1_sum;
      OP_SOBEL:         combine_c = signed'({1'b0, sobel_sum});
      OP_INV:           combine_c = 13'sd255 - ext(s1_centre);
      default:          combine_c = ext(s1_centre);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_result <= combine_c;
      o_valid  <= s1_valid;
    end
  end

endmodule

// File: rtl/conv3x3_filter.sv
// Streaming 3x3 convolution stage: per-line opcode latch, two-stage kernel,
// clamp stage and output pixel counter driving end-of-line.
module conv3x3_filter
  import img_proc_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [71:0] i_pixel_data,
  input  logic        i_pixel_data_valid,
  input  logic [3:0]  i_opcode,
  output logic [7:0]  o_pixel,
  output logic        o_pixel_valid,
  output logic        o_eol
);

  localparam int               CNT_W = $clog2(LINE_WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_WIDTH - 1);

  logic [CNT_W-1:0]         in_cnt, out_cnt;
  opcode_e                  op_q, op_eff;
  logic signed [TERM_W-1:0] k_result;
  logic                     k_valid;

  function automatic opcode_e decode_op(input logic [3:0] raw);
    return (raw > 4'h5) ? OP_PASS : opcode_e'(raw);
  endfunction

  // The first pixel of a line must already use the new opcode, so bypass the latch.
  assign op_eff = (i_pixel_data_valid && in_cnt == '0) ? decode_op(i_opcode) : op_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      in_cnt <= '0;
      op_q   <= OP_PASS;
    end else if (i_pixel_data_valid) begin
      op_q   <= op_eff;
      in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + CNT_W'(1);
    end
  end

  conv3x3_kernel u_kernel (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_window (i_pixel_data),
    .i_valid  (i_pixel_data_valid),
    .i_opcode (op_eff),
    .o_result (k_result),
    .o_valid  (k_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_eol         <= 1'b0;
      out_cnt       <= '0;
    end else begin
      o_pixel       <= clamp_u8(k_result);
      o_pixel_valid <= k_valid;
      o_eol         <= k_valid && (out_cnt == LAST);
      if (k_valid)
        out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/conv3x3_filter.md
# conv3x3_filter

Streaming 3x3 convolution stage that sits directly downstream of the four-line-buffer window generator. Each valid cycle it takes one 72-bit pixel window plus a 4-bit opcode and produces one filtered 8-bit pixel through a fixed three-stage pipeline. It also counts output pixels per line and flags end-of-line for the VGA/frame-writer stage that follows. There is no back-pressure; it accepts one window per cycle indefinitely.

## Interface
- LINE_WIDTH, 512: output pixels per line; sets the end-of-line count.
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-low reset (asserted when 0)
- i_pixel_data  in  72  3x3 window; bits [23:0] top row, [47:24] middle row, [71:48] bottom row; within a row, [23:16] left, [15:8] centre, [7:0] right (unsigned 8-bit)
- i_pixel_data_valid  in  1  window valid this cycle
- i_opcode  in  4  filter select
- o_pixel  out  8  filtered pixel
- o_pixel_valid  out  1  o_pixel valid this cycle
- o_eol  out  1  high together with the LINE_WIDTH-th valid output of a line

## Operation
- Notation: p[r][c], with r and c in 0..2, top-left = p[0][0].
- Opcodes:
  - 0x0: pass, p[1][1].
  - 0x1: Gaussian, (1 2 1 / 2 4 2 / 1 2 1) sum, then >>4, truncated.
  - 0x2: sharpen, 5·p11 − p01 − p10 − p12 − p21, clamped to 0..255.
  - 0x3: Sobel, |Gx|+|Gy|, saturated at 255. Gx = right column minus left column, weights 1,2,1. Gy = bottom row minus top row, weights 1,2,1.
  - 0x4: Laplacian, p01+p10+p12+p21 − 4·p11, clamped to 0..255. No abs.
  - 0x5: invert, 255 − p11.
  - 0x6–0xF: treated as 0x0.
- Opcode latching:
  - The opcode is sampled only on the first valid input of a line, when the input count is 0, and is held for the whole line.
  - Opcode changes mid-line take effect on the next line.
  - After reset the latched opcode is 0x0.
- Arithmetic:
  - All intermediate terms are 13-bit signed, which covers −1020..+4080 without overflow.
  - Sobel |Gx| and |Gy| are 11-bit each; their sum is 12-bit before saturation.
- Input pixel counter:
  - Counts 0..LINE_WIDTH−1 and increments on each i_pixel_data_valid.
  - Wraps to 0 after LINE_WIDTH−1.
  - Its only role is opcode latching.
- Output pixel counter:
  - Counts 0..LINE_WIDTH−1 and increments on each o_pixel_valid.
  - o_eol = o_pixel_valid && (count == LINE_WIDTH−1); the counter wraps to 0 on that cycle.
- Invalid cycles: the pipeline still shifts every clock and valid bits travel with the data. Data registers may hold stale values, but o_pixel is only meaningful when o_pixel_valid=1.

## Timing
- Latency: an input valid in cycle N gives o_pixel_valid in cycle N+3. Throughput is 1 pixel/cycle and gaps are preserved exactly.
- Pipeline stages:
  - S1 registers the per-opcode raw terms: weighted sum, Gx, Gy, centre, and the latched opcode.
  - S2 registers the combine step: abs, add, shift.
  - S3 registers the clamp/saturate into o_pixel and o_pixel_valid.
- Reset (i_rst=0 at a clock edge), applied on the next edge:
  - o_pixel=0, o_pixel_valid=0, o_eol=0.
  - All pipeline valid bits cleared; both counters 0; latched opcode 0x0.
  - Reset mid-line discards in-flight pixels and no o_eol is produced for the partial line.
- Line boundary: the first-pixel-of-line opcode latch and the eol of the previous line may coincide within the pipeline. Each pixel carries its own opcode through S1–S3, so there is no interference.
- Output counter wrap: LINE_WIDTH consecutive or gapped outputs produce exactly one o_eol pulse.

## Structure
- Shared package (img_proc_pkg):
  - opcode constants OP_PASS, OP_GAUSS, OP_SHARP, OP_SOBEL, OP_LAPL, OP_INV;
  - the LINE_WIDTH default;
  - the clamp-to-8-bit function.
- One sub-module, conv3x3_kernel:
  - holds the S1/S2 datapath (window and opcode in, 13-bit signed result plus valid out);
  - the top level holds the counters, opcode latch, clamp stage and o_eol.

## Test plan
- Gaussian, flat field: all nine pixels 100, opcode 0x1, 10 valids → ten outputs of 100, each exactly 3 cycles after its input.
- Sharpen, both clamps:
  - centre 200, rest 0, op 0x2 → 255;
  - centre 0, rest 255 → 0;
  - all 50 → 50.
- Sobel:
  - vertical edge (left column 0, right column 255, centre column 128), op 0x3 → 255;
  - all-equal window → 0;
  - top row 0, bottom row 10, others 5 → 40.
- Opcode latch: send 512 valids; switch i_opcode from 0x5 to 0x0 at pixel 100.
  - Pixels 0–511 are all inverted (p11=30 → 225), and exactly one o_eol appears, on the 512th output.
  - Next line's pixels pass through (30).
- Gapped stream: valids with random 0–3 idle cycles → output valid pattern equals the input pattern delayed 3 cycles; o_eol on the 512th output only.
- Reset mid-line: drive i_rst=0 after 200 valids with 3 in flight.
  - Outputs drop to 0/invalid on the next edge, and no further valids emerge.
  - After release, a new opcode is latched on the first pixel, and o_eol comes after 512 new outputs.
